// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FWFT FIFO.
// The optional FIFO_ERROR_FLAGS_EN build adds sticky overflow/underflow flags in the top.
package fifo_pkg;

    localparam int DEFAULT_SIZE          = 512;
    localparam int DEFAULT_WIDTH         = 8;
    localparam int DEFAULT_ALMOST_MARGIN = 4;
    localparam int ADDR_W                = $clog2(DEFAULT_SIZE);

    // Level needs one extra bit so that a completely full FIFO (SIZE) is representable.
    function automatic int clog2p1(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// It has no reset so that synthesis can map it onto block RAM.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_SIZE,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register holds its value until the next read is issued.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_fwft_level.sv
// Single-clock first-word-fall-through FIFO with fill level and threshold flags.
// Define FIFO_ERROR_FLAGS_EN to build the sticky o_overflow/o_underflow flags.
module fifo_fwft_level
    import fifo_pkg::*;
#(
    parameter int SIZE         = DEFAULT_SIZE,
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int ALMOST_FULL  = SIZE - DEFAULT_ALMOST_MARGIN,
    parameter int ALMOST_EMPTY = DEFAULT_ALMOST_MARGIN
) (
    input  logic                      i_master_clk,
    input  logic                      i_reset,
    input  logic                      i_write_enabled,
    input  logic [WIDTH-1:0]          i_write_data,
    input  logic                      i_write_data_valid,
    output logic                      o_write_full,
    output logic                      o_write_almost_full,
    output logic                      o_read_available,
    output logic [WIDTH-1:0]          o_read_data,
    input  logic                      i_read_data_consumed,
    output logic                      o_read_almost_empty,
    output logic [clog2p1(SIZE)-1:0]  o_level,
    output logic                      o_overflow,
    output logic                      o_underflow,
    input  logic                      i_clear_flags
);

    localparam int AW = $clog2(SIZE);
    localparam int LW = clog2p1(SIZE);
    localparam logic [LW-1:0] SIZE_L = LW'(SIZE);
    localparam logic [LW-1:0] AF_L   = LW'(ALMOST_FULL);
    localparam logic [LW-1:0] AE_L   = LW'(ALMOST_EMPTY);
    localparam logic          AF_RST = (ALMOST_FULL <= 0);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    ram_cnt;
    logic [LW-1:0]    level_next;
    logic             s1_valid;
    logic [WIDTH-1:0] ram_rdata;
    logic             wr_req;
    logic             wr_accept;
    logic             pop;
    logic             load_out;
    logic             issue;

    // Two-stage prefetch: the RAM read register (s1) feeds the output register.
    // A RAM read is issued only when s1 will be free to take its result.
    always_comb begin
        wr_req     = i_write_enabled && i_write_data_valid;
        wr_accept  = wr_req && !o_write_full;
        pop        = i_read_data_consumed && o_read_available;
        load_out   = s1_valid && (!o_read_available || pop);
        issue      = (ram_cnt != '0) && (!s1_valid || load_out);
        level_next = o_level + LW'(wr_accept) - LW'(pop);
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (SIZE),
        .AW    (AW)
    ) u_ram (
        .clk   (i_master_clk),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata (i_write_data),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            ram_cnt <= ram_cnt + LW'(wr_accept) - LW'(issue);
            if (issue) begin
                s1_valid <= 1'b1;
            end else if (load_out) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            o_read_available <= 1'b0;
            o_read_data      <= '0;
        end else if (load_out) begin
            o_read_available <= 1'b1;
            o_read_data      <= ram_rdata;
        end else if (pop) begin
            o_read_available <= 1'b0;
        end
    end

    // Flags are derived from the next level so they always agree with o_level.
    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            o_level             <= '0;
            o_write_full        <= 1'b0;
            o_write_almost_full <= AF_RST;
            o_read_almost_empty <= 1'b1;
        end else begin
            o_level             <= level_next;
            o_write_full        <= (level_next == SIZE_L);
            o_write_almost_full <= (level_next >= AF_L);
            o_read_almost_empty <= (level_next <= AE_L);
        end
    end

`ifdef FIFO_ERROR_FLAGS_EN
    // A new error takes priority over a clear in the same cycle.
    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_req && o_write_full) begin
                o_overflow <= 1'b1;
            end else if (i_clear_flags) begin
                o_overflow <= 1'b0;
            end
            if (i_read_data_consumed && !o_read_available) begin
                o_underflow <= 1'b1;
            end else if (i_clear_flags) begin
                o_underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_clear_flags;
    assign unused_clear_flags = i_clear_flags;
    assign o_overflow         = 1'b0;
    assign o_underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_fwft_level.sv
// Scoreboard bench for fifo_fwft_level (SIZE=8, ALMOST_FULL=6, ALMOST_EMPTY=2).
// Sticky-flag expectations follow FIFO_ERROR_FLAGS_EN when it is defined, else stay 0.
module tb_fifo_fwft_level;

    localparam int SIZE  = 8;
    localparam int WIDTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int LW    = $clog2(SIZE) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wen = 1'b0;
    logic             wvalid = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic             consume = 1'b0;
    logic             clear = 1'b0;

    logic             o_write_full;
    logic             o_write_almost_full;
    logic             o_read_available;
    logic [WIDTH-1:0] o_read_data;
    logic             o_read_almost_empty;
    logic [LW-1:0]    o_level;
    logic             o_overflow;
    logic             o_underflow;

    always #5 clk = ~clk;

    fifo_fwft_level #(
        .SIZE         (SIZE),
        .WIDTH        (WIDTH),
        .ALMOST_FULL  (AF),
        .ALMOST_EMPTY (AE)
    ) dut (
        .i_master_clk         (clk),
        .i_reset              (rst),
        .i_write_enabled      (wen),
        .i_write_data         (wdata),
        .i_write_data_valid   (wvalid),
        .o_write_full         (o_write_full),
        .o_write_almost_full  (o_write_almost_full),
        .o_read_available     (o_read_available),
        .o_read_data          (o_read_data),
        .i_read_data_consumed (consume),
        .o_read_almost_empty  (o_read_almost_empty),
        .o_level              (o_level),
        .o_overflow           (o_overflow),
        .o_underflow          (o_underflow),
        .i_clear_flags        (clear)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               wcyc;
    } entry_t;

    entry_t           mq[$];
    logic [WIDTH-1:0] expq[$];
    int               cyc = 0;
    int               last_pop = 0;
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;
    int               compared = 0;
    int               mismatched = 0;

    // Head word is visible two edges after its write, and never before its predecessor left.
    function automatic bit model_avail();
        int ready;
        if (mq.size() == 0) return 1'b0;
        ready = (mq[0].wcyc + 2 > last_pop) ? mq[0].wcyc + 2 : last_pop;
        return ready <= cyc;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit vld, input logic [WIDTH-1:0] d,
                                 input bit cons, input bit clr);
        @(posedge clk);
        #1;
        wen     = en;
        wvalid  = vld;
        wdata   = d;
        consume = cons;
        clear   = clr;
    endtask

    // Reference model: queue of stored words advanced on each active edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            expq.delete();
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            last_pop = 0;
        end else begin
            bit avail;
            bit req;
            bit full;
            avail = model_avail();
            req   = wen && wvalid;
            full  = (mq.size() == SIZE);
            cyc++;
            if (consume && avail) begin
                void'(mq.pop_front());
                last_pop = cyc;
            end
            if (consume && !avail) m_unf = 1'b1;
            else if (clear) m_unf = 1'b0;
            if (req && full) m_ovf = 1'b1;
            else if (clear) m_ovf = 1'b0;
            if (req && !full) begin
                mq.push_back('{wdata, cyc});
                expq.push_back(wdata);
            end
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each DUT handshake.
    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_word;
        bit exp_ovf;
        bit exp_unf;
`ifdef FIFO_ERROR_FLAGS_EN
        exp_ovf = m_ovf;
        exp_unf = m_unf;
`else
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
        checkOutput("level", int'(o_level), mq.size());
        checkOutput("full", int'(o_write_full), int'(mq.size() == SIZE));
        checkOutput("almost_full", int'(o_write_almost_full), int'(mq.size() >= AF));
        checkOutput("almost_empty", int'(o_read_almost_empty), int'(mq.size() <= AE));
        checkOutput("available", int'(o_read_available), int'(model_avail()));
        checkOutput("overflow", int'(o_overflow), int'(exp_ovf));
        checkOutput("underflow", int'(o_underflow), int'(exp_unf));
        if (o_read_available && consume) begin
            if (expq.size() == 0) begin
                checkOutput("pop_without_expected_word", 1, 0);
            end else begin
                exp_word = expq.pop_front();
                checkOutput("pop_data", int'(o_read_data), int'(exp_word));
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Single word fall-through, then pop it.
        applyStimulus(1, 1, 8'hA5, 0, 0);
        repeat (3) applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0);
        repeat (2) applyStimulus(0, 0, 8'h00, 0, 0);

        // Fill to full, drop one, drain back-to-back past empty.
        for (int i = 0; i < SIZE; i++) applyStimulus(1, 1, 8'(i), 0, 0);
        applyStimulus(1, 1, 8'hFF, 0, 0);
        repeat (3) applyStimulus(0, 0, 8'h00, 0, 0);
        repeat (SIZE + 2) applyStimulus(0, 0, 8'h00, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 0);

        // Underflow, clear, and clear colliding with a new underflow.
        applyStimulus(0, 0, 8'h00, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 1);
        applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 1);

        // Streaming: write every cycle, consume every cycle once data falls through.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 8'(i), 0, 0);
        for (int i = 3; i < 1000; i++) applyStimulus(1, 1, 8'(i), 1, 0);
        repeat (6) applyStimulus(0, 0, 8'h00, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 1);

        // Randomized traffic: write-heavy, then read-heavy, then balanced.
        for (int i = 0; i < 600; i++) begin
            int wr_bias;
            int rd_bias;
            wr_bias = (i < 200) ? 8 : (i < 400) ? 3 : 6;
            rd_bias = (i < 200) ? 3 : (i < 400) ? 8 : 6;
            applyStimulus($urandom_range(0, 9) < wr_bias, $urandom_range(0, 9) < 8,
                          8'($urandom), $urandom_range(0, 9) < rd_bias,
                          $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset with five words stored.
        repeat (SIZE + 4) applyStimulus(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 8'(8'h50 + i), 0, 0);
        repeat (3) applyStimulus(0, 0, 8'h00, 0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_level", int'(o_level), 0);
        checkOutput("rst_available", int'(o_read_available), 0);
        checkOutput("rst_data", int'(o_read_data), 0);
        checkOutput("rst_full", int'(o_write_full), 0);
        checkOutput("rst_almost_full", int'(o_write_almost_full), 0);
        checkOutput("rst_almost_empty", int'(o_read_almost_empty), 1);
        checkOutput("rst_overflow", int'(o_overflow), 0);
        checkOutput("rst_underflow", int'(o_underflow), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1, 8'h3C, 0, 0);
        repeat (3) applyStimulus(0, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0);
        repeat (3) applyStimulus(0, 0, 8'h00, 0, 0);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_fwft_level.md
Name: fifo_fwft_level

Overview:
- Parametrised single-clock FIFO for the renderer datapaths (command stream, pixel/span buffering between SPI/parser and rasteriser).
- Output is first-word-fall-through (FWFT): when o_read_available is high, o_read_data already holds the head word.
- Adds full, almost-full/almost-empty thresholds, a fill-level output and asynchronous reset.
- Error flags are optional.

Parameters:
- SIZE, 512: capacity in words; power of two, >= 4. Capacity counts all stored words, including the one presented on o_read_data.
- WIDTH, 8: data width in bits.
- ALMOST_FULL, SIZE-4: o_write_almost_full asserts when level >= ALMOST_FULL.
- ALMOST_EMPTY, 4: o_read_almost_empty asserts when level <= ALMOST_EMPTY.

Ports:
- i_master_clk  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_write_enabled  in  1  write port enable
- i_write_data  in  WIDTH  write data
- i_write_data_valid  in  1  write strobe; write request = enabled && valid
- o_write_full  out  1  level == SIZE
- o_write_almost_full  out  1  level >= ALMOST_FULL
- o_read_available  out  1  o_read_data holds a valid head word
- o_read_data  out  WIDTH  head word (FWFT)
- i_read_data_consumed  in  1  pop head word
- o_read_almost_empty  out  1  level <= ALMOST_EMPTY
- o_level  out  $clog2(SIZE)+1  stored word count, 0..SIZE
- o_overflow  out  1  sticky: write request dropped while full
- o_underflow  out  1  sticky: consume while not available
- i_clear_flags  in  1  synchronous clear of the sticky flags

Behaviour:
- Reset (asynchronous assert; release takes effect on the next clock edge):
  - pointers = 0, o_level = 0, o_read_available = 0, o_read_data = 0;
  - o_write_full = 0, o_write_almost_full = 0 (for ALMOST_FULL > 0), o_read_almost_empty = 1;
  - o_overflow = 0, o_underflow = 0.
- Reset mid-operation discards all contents immediately; RAM contents are not cleared.
- Storage:
  - RAM depth SIZE, read and write pointers of $clog2(SIZE) bits, wrapping naturally at SIZE-1 -> 0.
  - Plus one output register (prefetch stage).
  - The RAM read is registered, one cycle.
- Write:
  - Accepted when the request is high and o_write_full is low; the word is stored at edge N and the level increments.
  - A request while full is dropped. Full blocks the write even if a consume occurs in the same cycle; no write-through-when-full.
- Read / prefetch:
  - When the output stage is empty or being consumed, and the RAM holds data, the head word loads into o_read_data.
  - Write at edge N into an empty FIFO -> o_read_available = 1 after edge N+2. Fixed 2-cycle fall-through latency.
  - Consume with o_read_available = 1: the word is popped at that edge. If a further word is prefetched, o_read_available stays high with no bubble (back-to-back reads at one word per clock).
  - Consume with o_read_available = 0: ignored, and o_underflow is set.
- o_level:
  - +1 on an accepted write, -1 on a valid consume, unchanged when both happen in the same cycle.
  - Counts words in RAM, in flight in the read pipeline and in the output register.
  - Never exceeds SIZE and never goes below 0.
- All flags are registered and consistent with o_level in the same cycle.
- Simultaneous write and consume at level 1: both take effect, level stays 1, the new word follows with no gap beyond the fall-through latency.
- Sticky flags: i_clear_flags clears them. Clear and a new error in the same cycle -> the flag is set (error wins).

Optional Feature:
- FIFO_ERROR_FLAGS_EN defined:
  - o_overflow and o_underflow behave as above;
  - i_clear_flags is active.
- Not defined:
  - o_overflow and o_underflow are constant 0;
  - i_clear_flags is ignored;
  - no flag registers are synthesised.
- The port list is identical in both builds.

Decomposition:
- Package fifo_pkg:
  - level-width function clog2p1(SIZE);
  - default threshold constants;
  - localparam ADDR_W = $clog2(SIZE).
- Sub-module fifo_ram: simple dual-port RAM, one write port, one registered read port, WIDTH x SIZE. Inferred as block RAM.
- Pointer, level and prefetch control stay in fifo_fwft_level.

Test Plan:
- Reset, then write 0xA5 once: o_read_available rises exactly 2 clocks after the write edge, o_read_data = 0xA5, o_level = 1.
- SIZE=8: write 8 words 0..7 with no reads -> o_write_full = 1, o_level = 8. A 9th write (0xFF) is dropped and o_overflow = 1. Reading out returns 0..7 in order.
- Stream 1000 words with write and consume asserted every cycle after the first fall-through: no gaps, data in order across several pointer wraps, o_level constant.
- SIZE=8, ALMOST_FULL=6, ALMOST_EMPTY=2: fill to 6 -> almost_full = 1; drain to 2 -> almost_empty = 1. Both flags toggle at the exact level crossings.
- Consume pulse while empty -> o_underflow = 1 and level stays 0. i_clear_flags pulse -> flag clears. Clear in the same cycle as a new underflow -> flag stays 1.
- Assert i_reset asynchronously between clock edges with level 5: all outputs reach their reset values immediately. After release, a new write falls through as the first word read out.
